// File: rtl/ahb_slave_mbox_if_if.sv
// Purpose: bundles the AHB-Lite slave bus and the mailbox request/response signals of the bridge.
// Latency: none (wiring only).
// Backpressure: hreadyout stalls the AHB master; h_req_ready stalls the request side.
// Ports (slave view):
//   AHB in : hsel, haddr, htrans, hwrite, hsize, hwdata, hready
//   AHB out: hreadyout, hresp, hrdata
//   mailbox: h_req_valid/addr/wdata/write/sel out, h_req_ready in,
//            h_resp_valid/rdata/err in
interface ahb_slave_mbox_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    logic              h_req_valid;
    logic [ADDR_W-1:0] h_req_addr;
    logic [DATA_W-1:0] h_req_wdata;
    logic              h_req_write;
    logic [SEL_W-1:0]  h_req_sel;
    logic              h_req_ready;
    logic              h_resp_valid;
    logic [DATA_W-1:0] h_resp_rdata;
    logic [1:0]        h_resp_err;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output h_req_valid, h_req_addr, h_req_wdata, h_req_write, h_req_sel,
        input  h_req_ready, h_resp_valid, h_resp_rdata, h_resp_err
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  h_req_valid, h_req_addr, h_req_wdata, h_req_write, h_req_sel,
        output h_req_ready, h_resp_valid, h_resp_rdata, h_resp_err
    );
endinterface

// File: rtl/ahb_slave_mbox_if.sv
// Purpose: AHB-Lite slave front-end issuing one HCLK-side mailbox request per accepted transfer.
// Latency: h_req_valid one cycle after the address phase; data phase completes the cycle after the response pulse.
// Backpressure: hreadyout held low from accept until the response returns; h_req_valid held until h_req_ready.
// Ports: hclk, hresetn (async, active-low) plus the bus interface (slave modport):
//   AHB signals in/out and the mailbox request/response handshake.
// Optional: define AHB_SIZE_CHECK_EN to reject non-word or misaligned transfers with ERROR
//   and no mailbox request; without it hsize is ignored and every transfer is forwarded.
module ahb_slave_mbox_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int SEL_LSB = 12
) (
    input  logic hclk,
    input  logic hresetn,
    ahb_slave_mbox_if_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              size_bad;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic [DATA_W-1:0] hrdata_q;
    logic              req_valid_q;

`ifdef AHB_SIZE_CHECK_EN
    // Only aligned 32-bit transfers may reach the mailbox.
    assign size_bad = (bus.hsize != 3'b010) || (bus.haddr[1:0] != 2'b00);
`else
    logic unused_hsize;
    assign size_bad     = 1'b0;
    assign unused_hsize = ^bus.hsize;
`endif

    // Address phases are only looked at when the data phase of the previous
    // transfer is completing (IDLE, or the second ERROR cycle).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt = S_IDLE;
                if (bus.hsel && bus.hready && bus.htrans[1]) begin
                    accept    = 1'b1;
                    state_nxt = size_bad ? S_ERR1 : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.h_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Responses outside WAIT are stale or spurious and fall through untouched.
                if (bus.h_resp_valid) begin
                    state_nxt = (bus.h_resp_err == 2'b00) ? S_IDLE : S_ERR1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from next state so they line up with the state they describe.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            hreadyout_q <= (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
            hresp_q     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
            req_valid_q <= (state_nxt == S_REQ);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
        end
    end

    // Read data only changes on a successful read; writes and errors keep the old value.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata_q <= '0;
        end else if ((state == S_WAIT) && bus.h_resp_valid &&
                     (bus.h_resp_err == 2'b00) && !write_q) begin
            hrdata_q <= bus.h_resp_rdata;
        end
    end

    assign bus.hreadyout   = hreadyout_q;
    assign bus.hresp       = hresp_q;
    assign bus.hrdata      = hrdata_q;
    assign bus.h_req_valid = req_valid_q;
    assign bus.h_req_addr  = addr_q;
    assign bus.h_req_write = write_q;
    assign bus.h_req_sel   = addr_q[SEL_LSB +: SEL_W];
    // The master holds hwdata stable through the wait states, so it can pass straight through.
    assign bus.h_req_wdata = bus.hwdata;

endmodule
